fp_mult: RTL and testbench

Single-precision (IEEE-754 binary32) floating-point multiplier with a fixed-latency, reset-started computation. Each assertion of `reset` arms one multiplication. The first clock edge after reset releases samples `dataa` and `datab`. The product appears on `result` with `done` high a fixed number of cycles later. It is the multiply primitive of the synthesizer's floating-point datapath.

---
 rtl/fp_mult.sv | 112 +++++++++++
 tb/tb_fp_mult.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult.sv
// Reset-started binary32 multiplier: LOAD/MULT/NORM/DONE, result and done registered at the 4th edge after reset release.
// Denormal inputs flush to zero, round-to-nearest-even, no denormal outputs.
module fp_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {LOAD, MULT, NORM, DONE} state_e;

  state_e             state_q;
  logic               sign_q;
  logic [7:0]         ea_q, eb_q;
  logic [23:0]        ma_q, mb_q;
  logic               nan_q, inf_q, zero_q;
  logic [47:0]        prod_q;
  logic signed [9:0]  exp_q;
  logic [31:0]        res_q, result_q;
  logic               done_q;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // exponent 0 covers both true zero and denormals, which are flushed
  assign a_zero = (dataa[30:23] == 8'h00);
  assign b_zero = (datab[30:23] == 8'h00);
  assign a_inf  = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'h0);
  assign b_inf  = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'h0);
  assign a_nan  = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'h0);
  assign b_nan  = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'h0);

  logic [23:0]       mant_pre;
  logic              guard, sticky, round_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac_fin;
  logic signed [9:0] exp_n;
  logic [31:0]       res_d;

  always_comb begin
    mant_pre = prod_q[47] ? prod_q[47:24] : prod_q[46:23];
    guard    = prod_q[47] ? prod_q[23] : prod_q[22];
    // round and sticky bits folded together; only their OR matters for RNE
    sticky   = prod_q[47] ? (|prod_q[22:0]) : (|prod_q[21:0]);
    exp_n    = exp_q + $signed({9'b0, prod_q[47]});
    round_up = guard & (sticky | mant_pre[0]);
    mant_r   = {1'b0, mant_pre} + {24'b0, round_up};
    frac_fin = mant_r[22:0];
    if (mant_r[24]) begin
      frac_fin = mant_r[23:1];
      exp_n    = exp_n + 10'sd1;
    end
    res_d = {sign_q, exp_n[7:0], frac_fin};
    if (nan_q)                   res_d = 32'h7FC0_0000;
    else if (inf_q)              res_d = {sign_q, 8'hFF, 23'h0};
    else if (zero_q)             res_d = {sign_q, 31'h0};
    else if (exp_n >= 10'sd255)  res_d = {sign_q, 8'hFF, 23'h0};
    else if (exp_n <= 10'sd0)    res_d = {sign_q, 31'h0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      sign_q   <= 1'b0;
      ea_q     <= 8'h0;
      eb_q     <= 8'h0;
      ma_q     <= 24'h0;
      mb_q     <= 24'h0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      prod_q   <= 48'h0;
      exp_q    <= 10'sd0;
      res_q    <= 32'h0;
      result_q <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          sign_q  <= dataa[31] ^ datab[31];
          ea_q    <= dataa[30:23];
          eb_q    <= datab[30:23];
          ma_q    <= {1'b1, dataa[22:0]};
          mb_q    <= {1'b1, datab[22:0]};
          nan_q   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
          inf_q   <= a_inf | b_inf;
          zero_q  <= a_zero | b_zero;
          state_q <= MULT;
        end
        MULT: begin
          prod_q  <= {24'b0, ma_q} * {24'b0, mb_q};
          exp_q   <= $signed({2'b0, ea_q}) + $signed({2'b0, eb_q}) - 10'sd127;
          state_q <= NORM;
        end
        NORM: begin
          res_q   <= res_d;
          state_q <= DONE;
        end
        DONE: begin
          result_q <= res_q;
          done_q   <= 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fp_mult.sv
// Scoreboard bench for fp_mult: expected products queued at stimulus time, popped when done rises.
module tb_fp_mult;

  logic        clk;
  logic        reset;
  logic [31:0] dataa, datab;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  fp_mult dut (
    .clk    (clk),
    .reset  (reset),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle reset pulse with operands applied; returns at the negedge after release.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    reset = 1'b1;
    dataa = a;
    datab = b;
    exp_q.push_back(e);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Cycle count after release at which done was first seen (99 = timeout).
  task automatic wait_done(output int cyc, output logic [31:0] res);
    cyc = 99;
    res = 32'hx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    dataa = 32'h4000_0000;
    datab = 32'h4040_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || result !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: done=%b result=%h, want done=0 result=0", k, done, result);
      end
    end
  endtask

  task automatic test_vectors;
    logic [31:0] va[10];
    logic [31:0] vb[10];
    logic [31:0] ve[10];
    int cyc;
    logic [31:0] r, e;
    va = '{32'h4000_0000, 32'hBFA0_0000, 32'h0000_0000, 32'hC040_0000, 32'h7F80_0000,
           32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h3F80_0001, 32'h3FC0_0000};
    vb = '{32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, 32'hC030_0000, 32'h0000_0000,
           32'hBF80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h3F80_0001, 32'h3F80_0001};
    ve = '{32'h40C0_0000, 32'hBFF0_0000, 32'h0000_0000, 32'h4104_0000, 32'h7FC0_0000,
           32'hFF80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h3F80_0002, 32'h3FC0_0002};
    for (int i = 0; i < 10; i++) begin
      start_op(va[i], vb[i], ve[i]);
      wait_done(cyc, r);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 4) begin
        n_fail++;
        $display("FAIL vec%0d_latency: done at cycle %0d, want 4", i, cyc);
      end
      n_checks++;
      if (r !== e) begin
        n_fail++;
        $display("FAIL vec%0d_result: %h x %h = %h, want %h", i, va[i], vb[i], r, e);
      end
    end
  endtask

  task automatic test_rounding;
    int cyc;
    logic [31:0] r, e;
    // exact tie with even lsb: stays down
    start_op(32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004);
    wait_done(cyc, r);
    e = exp_q.pop_front();
    n_checks++;
    if (r !== e || cyc != 4) begin
      n_fail++;
      $display("FAIL tie_even: result=%h cyc=%0d, want %h at 4", r, cyc, e);
    end
    // mantissa overflow via bit47 normalisation: (2-ulp)^2
    start_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
    wait_done(cyc, r);
    e = exp_q.pop_front();
    n_checks++;
    if (r !== e || cyc != 4) begin
      n_fail++;
      $display("FAIL norm_shift: result=%h cyc=%0d, want %h at 4", r, cyc, e);
    end
  endtask

  task automatic test_latency_hold;
    logic [31:0] e;
    start_op(32'hC040_0000, 32'hC030_0000, 32'h4104_0000);
    e = exp_q.pop_front();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dataa = 32'h3F80_0000;
        datab = 32'h7F80_0000;
      end
      n_checks++;
      if (done !== 1'b0 || result !== 32'h0) begin
        n_fail++;
        $display("FAIL early_E%0d: done=%b result=%h, want 0/0", k, done, result);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || result !== e) begin
      n_fail++;
      $display("FAIL at_E4: done=%b result=%h, want 1/%h", done, result, e);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 5) dataa = 32'h0000_0000;
      n_checks++;
      if (done !== 1'b1 || result !== e) begin
        n_fail++;
        $display("FAIL hold%0d: done=%b result=%h, want 1/%h", k, done, result, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [31:0] r, e;
    start_op(32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    dataa = 32'h4000_0000;
    datab = 32'h4040_0000;
    exp_q.push_back(32'h40C0_0000);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_E2: done=%b result=%h, want 0/0", done, result);
    end
    reset = 1'b0;
    wait_done(cyc, r);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc != 4 || r !== e) begin
      n_fail++;
      $display("FAIL restart: result=%h cyc=%0d, want %h at 4", r, cyc, e);
    end
    // reset after completion clears the held outputs
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_done: done=%b result=%h, want 0/0", done, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [31:0] r, e;
    for (int i = 0; i < 4; i++) begin
      start_op(32'h3F80_0000 + (i << 23), 32'h4000_0000, 32'h4000_0000 + (i << 23));
      wait_done(cyc, r);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 4 || r !== e) begin
        n_fail++;
        $display("FAIL b2b%0d: result=%h cyc=%0d, want %h at 4", i, r, cyc, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    dataa = 32'h0;
    datab = 32'h0;
    test_reset();
    test_vectors();
    test_rounding();
    test_latency_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
